// File: rtl/mig_cmd_issuer.sv
// mig_cmd_issuer
//   Read-side consumer of the command async FIFO, running in the MIG UI clock
//   domain. Pops one {cmd,addr,len} entry at a time and expands it into len+1
//   MIG app-interface commands at consecutive addresses, honouring app_rdy.
//
// Ports
//   clk       MIG UI clock (FIFO read clock)
//   rst       asynchronous, active-high reset
//   rqempty   FIFO empty; rdata valid when 0
//   rdata     head entry {cmd(1 rd / 0 wr), addr[ADRW], len[LENW]}
//   rnext     one-cycle pop strobe to the FIFO
//   app_en    MIG command valid
//   app_cmd   3'b001 read, 3'b000 write
//   app_addr  MIG command address
//   app_rdy   MIG accepts a command when app_en & app_rdy
//   busy      1 while an entry is held
//   cmd_done  one-cycle pulse on acceptance of an entry's last beat
//
// Optional feature (macro MIG_CMD_STAT_EN)
//   Adds saturating 16-bit counters stat_rd_cnt / stat_wr_cnt (accepted beats
//   by type) and stat_stall_cnt (cycles with app_en & ~app_rdy).

module mig_cmd_issuer #(
  parameter int ADRW      = 28,
  parameter int LENW      = 8,
  parameter int ADDR_STEP = 8,
  parameter int AFIFODW   = 1 + ADRW + LENW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rqempty,
  input  logic [AFIFODW-1:0] rdata,
  output logic               rnext,
  output logic               app_en,
  output logic [2:0]         app_cmd,
  output logic [ADRW-1:0]    app_addr,
  input  logic               app_rdy,
  output logic               busy,
`ifdef MIG_CMD_STAT_EN
  output logic [15:0]        stat_rd_cnt,
  output logic [15:0]        stat_wr_cnt,
  output logic [15:0]        stat_stall_cnt,
`endif
  output logic               cmd_done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]      r_state;
  logic            r_cur_cmd;
  logic [ADRW-1:0] r_cur_addr;
  logic [LENW-1:0] r_remain;

  logic w_issue;
  logic w_accept;
  logic w_last;
  logic w_cap;

  assign w_issue  = (r_state == S_ISSUE);
  assign w_accept = w_issue & app_rdy;
  assign w_last   = w_accept & (r_remain == '0);
  // Popping in the last-beat cycle gives back-to-back entries with no bubble.
  // rqempty reflects a registered read pointer, so it is already valid here.
  assign w_cap    = ~rqempty & (~w_issue | w_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur_cmd  <= 1'b0;
      r_cur_addr <= '0;
      r_remain   <= '0;
    end else if (w_cap) begin
      r_state    <= S_ISSUE;
      r_cur_cmd  <= rdata[AFIFODW-1];
      r_cur_addr <= rdata[ADRW+LENW-1:LENW];
      r_remain   <= rdata[LENW-1:0];
    end else if (w_accept) begin
      if (w_last) begin
        r_state <= S_IDLE;
      end else begin
        // Address wraps naturally modulo 2^ADRW.
        r_cur_addr <= r_cur_addr + ADRW'(ADDR_STEP);
        r_remain   <= r_remain - LENW'(1);
      end
    end
  end

  assign rnext    = w_cap;
  assign app_en   = w_issue;
  assign app_cmd  = {2'b00, r_cur_cmd};
  assign app_addr = r_cur_addr;
  assign busy     = w_issue;
  assign cmd_done = w_last;

`ifdef MIG_CMD_STAT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = w_issue & ~app_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept & r_cur_cmd & (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_accept & ~r_cur_cmd & (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      if (w_stall & (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign stat_rd_cnt    = r_rd_cnt;
  assign stat_wr_cnt    = r_wr_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule
